// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between two byte requesters
module uart_tx_arbiter #(
    parameter int DW           = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic          clk_s,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    output logic          ack0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    output logic          ack1,
    input  logic          tx_busy,
    output logic          tx_send,
    output logic [DW-1:0] tx_data,
    output logic          owner,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(BUSY_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic [7:0] cnt;
    logic       grant;
    logic       grant_idx;
    logic       timeout;
    logic       enter_ack;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_idx = last_grant;
        timeout   = 1'b0;
        enter_ack = 1'b0;
        case (state)
            IDLE: begin
                // A busy transmitter (e.g. a frame left over from before reset) blocks grants.
                if (!tx_busy && (req0 || req1)) begin
                    grant     = 1'b1;
                    grant_idx = (req0 && req1) ? ~last_grant : req1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    enter_ack = 1'b1;
                    state_nxt = ACK;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    enter_ack = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_s or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= 8'd0;
            tx_send    <= 1'b0;
            tx_data    <= '0;
            owner      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_send <= (state_nxt == SEND);
            ack0    <= enter_ack && !owner;
            ack1    <= enter_ack && owner;
            if (grant) begin
                owner      <= grant_idx;
                last_grant <= grant_idx;
                tx_data    <= grant_idx ? data1 : data0;
                cnt        <= 8'd0;
            end else if (state == SEND) begin
                cnt <= cnt + 8'd1;
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule
